// File: rtl/regset_wb_arbiter.sv
// ============================================================================
// Module   : regset_wb_arbiter
// Purpose  : Round-robin ALU/LSU write-back arbiter with registered write
//            stage and pending-load scoreboard for read-hazard detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regset_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_addr,
  input  logic [AW-1:0]   rd_addr0,
  input  logic [AW-1:0]   rd_addr1,
  output logic            hz0,
  output logic            hz1,
  output logic [XLEN-1:0] D,
  output logic [AW-1:0]   A_D,
  output logic            write_enable
);

  localparam int NREG = 2**AW;

  // Bit 0 exists only to allow direct indexing by address; it stays zero.
  logic [NREG-1:0] pending_q, pending_d;
  logic            last_q, last_d;
  logic [XLEN-1:0] d_q, d_d;
  logic [AW-1:0]   a_q, a_d;
  logic            we_q, we_d;

  logic alu_elig, lsu_elig, gnt_alu, gnt_lsu;

  always_comb begin
    alu_elig = alu_valid && !((alu_addr != '0) && pending_q[alu_addr]);
    lsu_elig = lsu_valid;
    // On contention the requester that did not win last time is served.
    gnt_alu  = alu_elig && (!lsu_elig || last_q);
    gnt_lsu  = lsu_elig && (!alu_elig || !last_q);
    alu_ready = gnt_alu && !RES;
    lsu_ready = gnt_lsu && !RES;
  end

  always_comb begin
    d_d       = d_q;
    a_d       = a_q;
    we_d      = 1'b0;
    last_d    = last_q;
    pending_d = pending_q;
    if (alu_ready) begin
      d_d    = alu_data;
      a_d    = alu_addr;
      we_d   = (alu_addr != '0);
      last_d = 1'b0;
    end else if (lsu_ready) begin
      d_d    = lsu_data;
      a_d    = lsu_addr;
      we_d   = (lsu_addr != '0);
      last_d = 1'b1;
    end
    if (lsu_ready && (lsu_addr != '0))
      pending_d[lsu_addr] = 1'b0;
    // A newly issued load supersedes a completing one to the same register.
    if (issue_valid && (issue_addr != '0))
      pending_d[issue_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      pending_q <= '0;
      last_q    <= 1'b1;
      d_q       <= '0;
      a_q       <= '0;
      we_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      last_q    <= last_d;
      d_q       <= d_d;
      a_q       <= a_d;
      we_q      <= we_d;
    end
  end

  // The register set reads asynchronously, so an in-flight write is a hazard.
  always_comb begin
    hz0 = (rd_addr0 != '0) && (pending_q[rd_addr0] || (we_q && (a_q == rd_addr0)));
    hz1 = (rd_addr1 != '0) && (pending_q[rd_addr1] || (we_q && (a_q == rd_addr1)));
  end

  assign D            = d_q;
  assign A_D          = a_q;
  assign write_enable = we_q;

endmodule

`default_nettype wire

// File: tb/tb_regset_wb_arbiter.sv
// ============================================================================
// Module   : tb_regset_wb_arbiter
// Purpose  : Directed self-checking bench for regset_wb_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regset_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RES;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_addr, lsu_addr, issue_addr, rd_addr0, rd_addr1;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, hz0, hz1, write_enable;
  logic [31:0] D;
  logic [4:0]  A_D;

  int total = 0;
  int bad   = 0;

  regset_wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .CLK(CLK), .RES(RES),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .hz0(hz0), .hz1(hz1),
    .D(D), .A_D(A_D), .write_enable(write_enable)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int ai, li;
    logic exp_alu;
    RES = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    lsu_valid = 1'b0; lsu_addr = '0;   lsu_data = '0;
    issue_valid = 1'b0; issue_addr = '0;
    rd_addr0 = '0; rd_addr1 = '0;

    // Reset: outputs quiet, request not accepted
    tick();
    chk("rst_we", write_enable, 0);
    chk("rst_D", D, 0);
    chk("rst_AD", A_D, 0);
    chk("rst_alu_ready", alu_ready, 0);
    tick();
    RES = 1'b0;
    #1;
    chk("first_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("first_we", write_enable, 1);
    chk("first_AD", A_D, 5);
    chk("first_D", D, 32'hDEADBEEF);
    tick();
    chk("idle_we", write_enable, 0);
    chk("idle_D_hold", D, 32'hDEADBEEF);

    // Contention after a fresh reset: ALU first, then alternate
    RES = 1'b1;
    tick();
    RES = 1'b0;
    ai = 0; li = 0;
    for (int k = 0; k < 8; k++) begin
      alu_valid = (ai < 4); alu_addr = 5'(1 + ai); alu_data = 32'h100 + 32'(ai);
      lsu_valid = (li < 4); lsu_addr = 5'(8 + li); lsu_data = 32'h800 + 32'(li);
      exp_alu = ((k % 2) == 0);
      #1;
      chk("cont_alu_ready", alu_ready, exp_alu);
      chk("cont_lsu_ready", lsu_ready, !exp_alu);
      tick();
      chk("cont_we", write_enable, 1);
      chk("cont_AD", A_D, exp_alu ? 32'(1 + ai) : 32'(8 + li));
      chk("cont_D", D, exp_alu ? 32'h100 + 32'(ai) : 32'h800 + 32'(li));
      if (exp_alu) ai++; else li++;
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;

    // Scoreboard and WAW blocking on x7
    issue_valid = 1'b1; issue_addr = 5'd7;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hAAAA;
    rd_addr0 = 5'd7;
    #1;
    chk("waw_alu_blocked", alu_ready, 0);
    chk("waw_hz0_pending", hz0, 1);
    lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h1234;
    #1;
    chk("waw_lsu_ready", lsu_ready, 1);
    chk("waw_alu_still_blocked", alu_ready, 0);
    tick();
    lsu_valid = 1'b0;
    #1;
    chk("waw_lsu_we", write_enable, 1);
    chk("waw_lsu_D", D, 32'h1234);
    chk("waw_alu_ready_rises", alu_ready, 1);
    chk("waw_hz0_outstage", hz0, 1);
    alu_valid = 1'b0;
    tick();
    chk("waw_hz0_drops", hz0, 0);

    // x0 handling: handshakes complete, nothing written, no hazard
    issue_valid = 1'b1; issue_addr = 5'd0;
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h55;
    lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h66;
    rd_addr0 = 5'd0;
    #1;
    chk("x0_alu_ready", alu_ready, 1);
    chk("x0_lsu_wait", lsu_ready, 0);
    tick();
    alu_valid = 1'b0; issue_valid = 1'b0;
    #1;
    chk("x0_we_alu", write_enable, 0);
    chk("x0_lsu_ready", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0;
    chk("x0_we_lsu", write_enable, 0);
    chk("x0_hz0", hz0, 0);

    // Set/clear collision on x3
    rd_addr1 = 5'd3;
    issue_valid = 1'b1; issue_addr = 5'd3;
    tick();
    lsu_valid = 1'b1; lsu_addr = 5'd3; lsu_data = 32'h33;
    #1;
    chk("coll_lsu_ready", lsu_ready, 1);
    chk("coll_hz1_pre", hz1, 1);
    tick();
    issue_valid = 1'b0; lsu_valid = 1'b0;
    chk("coll_we", write_enable, 1);
    chk("coll_AD", A_D, 3);
    tick();
    chk("coll_hz1_kept", hz1, 1);

    // Reset mid-operation with x9 pending
    issue_valid = 1'b1; issue_addr = 5'd9; rd_addr0 = 5'd9;
    tick();
    issue_valid = 1'b0;
    chk("mid_hz0_pending", hz0, 1);
    alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hC0C0;
    #1;
    chk("mid_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("mid_we_before_rst", write_enable, 1);
    RES = 1'b1;
    tick();
    RES = 1'b0;
    chk("mid_we_cleared", write_enable, 0);
    chk("mid_hz0_cleared", hz0, 0);
    chk("mid_hz1_cleared", hz1, 0);
    chk("mid_D_cleared", D, 0);
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
    #1;
    chk("mid_alu_x9_ok", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("mid_alu_x9_AD", A_D, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regset_wb_arbiter.md
# regset_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32 x 32-bit register set. The ALU and the load/store unit (LSU) share the register set's single synchronous write port through valid/ready handshakes. Accepted writes go into a registered output stage that drives the register set's `D`, `A_D` and `write_enable`. A 31-entry pending bitmap tracks outstanding LSU loads and produces read-hazard flags for the decode stage's two source addresses.

## Interface
Parameters:
- `XLEN`, default 32: data width.
- `AW`, default 5: register address width (2**AW registers, x0 hardwired zero).

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RES`  in  1  reset, synchronous, active-high.
- `alu_valid`  in  1  ALU write-back request.
- `alu_addr`  in  AW  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle (combinational).
- `lsu_valid`  in  1  LSU load-data write-back request.
- `lsu_addr`  in  AW  LSU destination register.
- `lsu_data`  in  XLEN  load data.
- `lsu_ready`  out  1  LSU request accepted this cycle (combinational).
- `issue_valid`  in  1  a load to `issue_addr` was issued; marks the register pending.
- `issue_addr`  in  AW  destination of the issued load.
- `rd_addr0`, `rd_addr1`  in  AW  decode-stage source addresses.
- `hz0`, `hz1`  out  1  source register not yet valid in the register set (combinational).
- `D`  out  XLEN  write data to the register set (registered).
- `A_D`  out  AW  write address to the register set (registered).
- `write_enable`  out  1  write strobe to the register set (registered).

## Operation
- **Eligibility:**
  - ALU eligible = `alu_valid` && !(`alu_addr` != 0 && `pending[alu_addr]`). An ALU write to a register with a load outstanding waits; this prevents WAW reordering.
  - LSU eligible = `lsu_valid`.
- **Arbitration:** round-robin with a 1-bit `last` pointer (0 = ALU, 1 = LSU).
  - One eligible requester: it is granted.
  - Both eligible: the requester not equal to `last` is granted.
  - `last` updates to the granted requester on every grant; it is unchanged when there is no grant.
- **Ready rule:** `x_ready` = grant to x, and it is low while `RES` is high. At most one grant per cycle. Transfer occurs when valid && ready.
- **Output stage:** on a transfer, the next cycle presents `D` = data and `A_D` = addr.
  - `write_enable` = 1 only if addr != 0; writes to x0 are consumed and dropped.
  - With no transfer, `write_enable` = 0 and `D`/`A_D` hold their previous values.
- **Scoreboard `pending[31:1]`:**
  - Set: `issue_valid` && `issue_addr` != 0 sets `pending[issue_addr]`.
  - Clear: an LSU transfer with `lsu_addr` != 0 clears `pending[lsu_addr]`.
  - Set and clear of the same address in the same cycle: set wins (the new load supersedes the old one).
  - An LSU write to a non-pending address is written normally, with no scoreboard change.
- **Hazards:** `hzN` = (`rd_addrN` != 0) && (`pending[rd_addrN]` || (`write_enable` && `A_D` == `rd_addrN`)).
  - The output-stage term is required because the register set read is asynchronous: it still returns the old value during the write cycle.
- **Reset:** while `RES` is high, on each clock edge:
  - `pending` = 0, `last` = 1 (so the ALU wins the first contention), `write_enable` = 0, `D` = 0, `A_D` = 0.
  - A reset arriving mid-stream discards the output-stage write and all pending marks. Requesters must re-present their requests after `RES` deasserts.

## Timing
- Latency: transfer in cycle N gives `write_enable` high in cycle N+1. The register set holds the value from the edge ending cycle N+1; an asynchronous read returns it in cycle N+2.
- `hzN` covers cycles N+1 (output-stage term) and earlier (pending term). It deasserts in cycle N+2 for an LSU write that cleared the last pending mark.
- Throughput: one write per cycle, sustained. Under continuous dual contention, grants alternate ALU, LSU, ALU, ...
- `issue_valid` in cycle N sets `pending` from cycle N+1. The `hzN` flag for that address asserts from cycle N+1.
- Requesters hold `valid`, `addr` and `data` stable until ready; the block does not buffer unaccepted requests.

## Test plan
- **Reset:** `RES`=1 for 2 cycles, then ALU writes 0xDEADBEEF to x5 → `write_enable`=1, `A_D`=5, `D`=0xDEADBEEF exactly one cycle after `alu_ready`; all outputs 0 during reset.
- **Contention:** both valid continuously, ALU to x1..x4 and LSU to x8..x11 → grants alternate ALU, LSU, ALU, LSU; 8 writes in 8 consecutive cycles; ALU is granted first after reset.
- **Scoreboard and WAW block:** issue a load to x7, then ALU valid to x7 → `alu_ready`=0 and `hz0`=1 with `rd_addr0`=7. Then LSU writes 0x1234 to x7 → `alu_ready` rises the following cycle and `hz0` drops two cycles after the LSU transfer.
- **x0 handling:** `issue_valid` to x0 with ALU/LSU writes to x0 → handshakes complete, `write_enable` stays 0, `hz0`=0 with `rd_addr0`=0.
- **Set/clear collision:** LSU write to x3 in the same cycle as `issue_valid` to x3 → `pending[3]` remains 1 and `hz1` stays 1 with `rd_addr1`=3.
- **Reset mid-operation:** assert `RES` in the cycle after a transfer while x9 is pending → next cycle `write_enable`=0, `pending` all clear, `hz0`=0 with `rd_addr0`=9.
